sdram_read_streamer: RTL and testbench
======================================

// Module: sdram_read_streamer
// PURPOSE
// - Upstream client of the SDRAM controller: streams a run of consecutive 32-bit words out of SDRAM.
// - Given a start address and a word count, issues single-word reads over the RW_READ/RW_ACK handshake.
// - Buffers returned words in a small show-ahead FIFO, popped by a valid/ready consumer (e.g. frame/line logic).
// PARAMETERS
// - FIFO_DEPTH  16  read-data FIFO entries; power of two, >= 2
// - LEN_W       16  width of WORD_COUNT; max run = 2**LEN_W-1 words
// PORTS
// - SDRAM_CONTROLLER_CLK  in   1       clock (same domain as the SDRAM controller FSM)
// - Reset       in   1       synchronous, active-high
// - INIT_DONE   in   1       one-cycle pulse from controller when SDRAM init completes
// - Start       in   1       request a run; sampled only when Busy=0 and init seen
// - START_ADDR  in   25      first word address {bank[24:23], row[22:10], col[9:0]}
// - WORD_COUNT  in   LEN_W   number of words in the run
// - Busy        out  1       run in progress
// - Done        out  1       one-cycle pulse: last word of the run written into the FIFO
// - DATA_ADDR   out  25      address to controller, held stable while RW_READ=1
// - RW_READ     out  1       read request to controller
// - RW_WRITE    out  1       constant 0
// - RW_ACK      in   1       controller ack; DATA_READ valid only in this cycle
// - DATA_READ   in   32      read data from controller
// - OUT_DATA    out  32      FIFO head word (show-ahead)
// - OUT_VALID   out  1       FIFO not empty
// - OUT_READY   in   1       consumer pops head when OUT_VALID & OUT_READY
// BEHAVIOUR
// - Reset values: Busy=0, Done=0, RW_READ=0, RW_WRITE=0, DATA_ADDR=0, OUT_VALID=0, FIFO empty, init_seen=0.
// - init_seen latches on INIT_DONE pulse and clears only on Reset; Start ignored while init_seen=0.
// - FSM: IDLE -> ISSUE -> WAIT_ACK -> (ISSUE | FINISH) ; FINISH -> IDLE. All outputs registered.
// - IDLE: Start & init_seen: WORD_COUNT=0 -> FINISH (Done next cycle, no request);
//   else latch addr/remaining, Busy=1, -> ISSUE.
// - ISSUE: wait until fifo_count < FIFO_DEPTH; then RW_READ<=1, DATA_ADDR<=cur_addr, -> WAIT_ACK.
// - WAIT_ACK: hold RW_READ/DATA_ADDR. On RW_ACK: push DATA_READ, RW_READ<=0, cur_addr+=1,
//   remaining-=1; remaining was 1 -> FINISH, else -> ISSUE.
// - FINISH: Done=1 for exactly one cycle, Busy<=0, -> IDLE.
// - Latency: Start at cycle N -> RW_READ=1 at N+1 (FIFO has space). RW_ACK at M -> OUT_VALID=1 and
//   RW_READ=0 at M+1; earliest next RW_READ=1 at M+2 (>=1 low cycle between requests).
// - At most one outstanding request; issuing only at count<DEPTH guarantees room for its data.
// - FIFO: push and pop in same cycle -> count unchanged; pop when empty ignored; push never hits full.
// - Address arithmetic: 25-bit unsigned, wraps 0x1FFFFFF -> 0x0000000.
// - RW_ACK when not in WAIT_ACK ignored (no push). Start while Busy=1 ignored.
// - Done asserts when last word enters FIFO, not when consumed; FIFO contents survive into next run.
// - Reset mid-run: all state to reset values immediately, FIFO flushed, no Done.
// CONFIGURATION
// - SDRAM_READ_STREAMER_ABORT_EN defined: extra input Abort (1b). Abort in ISSUE/IDLE-with-Busy
//   -> FINISH-less return to IDLE next cycle, FIFO flushed. Abort in WAIT_ACK: keep RW_READ
//   until RW_ACK (controller can't cancel), discard that word, flush FIFO, -> IDLE; no Done on abort.
// - Undefined: no Abort port; runs always complete.
// TESTING
// - Start before INIT_DONE pulse -> no RW_READ; pulse INIT_DONE, Start again -> RW_READ=1 next cycle.
// - START_ADDR=0x0000400, WORD_COUNT=4, OUT_READY=1, ack data 0xA0..0xA3 -> DATA_ADDR 0x400..0x403
//   in order, OUT_DATA 0xA0..0xA3, one Done pulse, Busy=0 after.
// - WORD_COUNT=20, OUT_READY=0 -> exactly 16 reads issued, RW_READ stays 0; raise OUT_READY ->
//   remaining 4 issued, 20 words popped in order, Done once.
// - START_ADDR=0x1FFFFFE, WORD_COUNT=3 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000.
// - WORD_COUNT=0 -> Done pulse 2 cycles after Start, RW_READ never asserted; spurious RW_ACK in IDLE -> no push.
// - Reset asserted in WAIT_ACK with 3 words buffered -> next cycle RW_READ=0, OUT_VALID=0, Busy=0, no Done.

Source files
------------

// File: rtl/sdram_read_streamer.sv
// Streams a run of consecutive 32-bit SDRAM words through single-word RW_READ/RW_ACK reads into a show-ahead FIFO.
// Optional feature: define SDRAM_READ_STREAMER_ABORT_EN to add the Abort input that cancels a run.
module sdram_read_streamer #(
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 16
) (
   input  logic             SDRAM_CONTROLLER_CLK,
   input  logic             Reset,
   input  logic             INIT_DONE,
   input  logic             Start,
   input  logic [24:0]      START_ADDR,
   input  logic [LEN_W-1:0] WORD_COUNT,
   output logic             Busy,
   output logic             Done,
   output logic [24:0]      DATA_ADDR,
   output logic             RW_READ,
   output logic             RW_WRITE,
   input  logic             RW_ACK,
   input  logic [31:0]      DATA_READ,
   output logic [31:0]      OUT_DATA,
   output logic             OUT_VALID,
   input  logic             OUT_READY
`ifdef SDRAM_READ_STREAMER_ABORT_EN
   ,
   input  logic             Abort
`endif
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, FINISH} state_t;

   state_t           state, state_nxt;
   logic             init_seen;
   logic             abort_now, abort_pending, abort_pending_nxt;
   logic             busy_nxt, done_nxt, read_nxt;
   logic [24:0]      addr_nxt, cur_addr, cur_addr_nxt;
   logic [LEN_W-1:0] remaining, remaining_nxt;
   logic             push, pop, flush, fifo_space;

   logic [31:0]      fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    fifo_count;

`ifdef SDRAM_READ_STREAMER_ABORT_EN
   assign abort_now = Abort;
`else
   assign abort_now = 1'b0;
`endif

   assign RW_WRITE   = 1'b0;
   assign OUT_VALID  = (fifo_count != '0);
   assign OUT_DATA   = fifo_mem[rd_ptr];
   assign pop        = OUT_VALID & OUT_READY;
   // Only issue when the FIFO has a free slot, so the single outstanding read always has room.
   assign fifo_space = (fifo_count < CW'(FIFO_DEPTH));

   always_ff @(posedge SDRAM_CONTROLLER_CLK) begin
      if (Reset)
         init_seen <= 1'b0;
      else if (INIT_DONE)
         init_seen <= 1'b1;
   end

   // NOTE: every registered output comes straight from a flop; the comb block below only computes next values.
   always_ff @(posedge SDRAM_CONTROLLER_CLK) begin
      if (Reset) begin
         state         <= IDLE;
         Busy          <= 1'b0;
         Done          <= 1'b0;
         RW_READ       <= 1'b0;
         DATA_ADDR     <= '0;
         cur_addr      <= '0;
         remaining     <= '0;
         abort_pending <= 1'b0;
      end else begin
         state         <= state_nxt;
         Busy          <= busy_nxt;
         Done          <= done_nxt;
         RW_READ       <= read_nxt;
         DATA_ADDR     <= addr_nxt;
         cur_addr      <= cur_addr_nxt;
         remaining     <= remaining_nxt;
         abort_pending <= abort_pending_nxt;
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt         = state;
      busy_nxt          = Busy;
      done_nxt          = 1'b0;
      read_nxt          = RW_READ;
      addr_nxt          = DATA_ADDR;
      cur_addr_nxt      = cur_addr;
      remaining_nxt     = remaining;
      abort_pending_nxt = abort_pending;
      push              = 1'b0;
      flush             = 1'b0;

      unique case (state)
         IDLE: begin
            abort_pending_nxt = 1'b0;
            if (Start && init_seen) begin
               if (WORD_COUNT == '0) begin
                  state_nxt = FINISH;
               end else begin
                  busy_nxt      = 1'b1;
                  cur_addr_nxt  = START_ADDR;
                  remaining_nxt = WORD_COUNT;
                  // Skip the ISSUE cycle when space is already available so RW_READ follows Start directly.
                  if (fifo_space) begin
                     read_nxt  = 1'b1;
                     addr_nxt  = START_ADDR;
                     state_nxt = WAIT_ACK;
                  end else begin
                     state_nxt = ISSUE;
                  end
               end
            end
         end
         ISSUE: begin
            if (abort_now) begin
               flush     = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else if (fifo_space) begin
               read_nxt  = 1'b1;
               addr_nxt  = cur_addr;
               state_nxt = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            abort_pending_nxt = abort_pending | abort_now;
            if (RW_ACK) begin
               read_nxt      = 1'b0;
               cur_addr_nxt  = cur_addr + 25'd1;
               remaining_nxt = remaining - LEN_W'(1);
               // The controller cannot cancel a read, so an abort waits for the ack and drops that word.
               if (abort_pending || abort_now) begin
                  flush             = 1'b1;
                  busy_nxt          = 1'b0;
                  abort_pending_nxt = 1'b0;
                  state_nxt         = IDLE;
               end else begin
                  push      = 1'b1;
                  state_nxt = (remaining == LEN_W'(1)) ? FINISH : ISSUE;
               end
            end
         end
         FINISH: begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge SDRAM_CONTROLLER_CLK) begin
      if (Reset || flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by the pointers and count alone.
   always_ff @(posedge SDRAM_CONTROLLER_CLK) begin
      if (push) fifo_mem[wr_ptr] <= DATA_READ;
   end

endmodule

// File: tb/tb_sdram_read_streamer.sv
// Directed bench for sdram_read_streamer: a small SDRAM controller model acks reads,
// and address/data scoreboards hold the expected sequences.
module tb_sdram_read_streamer;

   localparam int DEPTH = 16;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             Reset, INIT_DONE, Start;
   logic [24:0]      START_ADDR;
   logic [LEN_W-1:0] WORD_COUNT;
   logic             Busy, Done, RW_READ, RW_WRITE, RW_ACK, OUT_VALID, OUT_READY;
   logic [24:0]      DATA_ADDR;
   logic [31:0]      DATA_READ, OUT_DATA;
`ifdef SDRAM_READ_STREAMER_ABORT_EN
   logic             abort = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int reads = 0;
   int done_cnt = 0;
   int ack_wait = 0;
   int ack_lat = 1;
   int done0;

   logic [24:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   always #5 clk = ~clk;

   sdram_read_streamer #(.FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .SDRAM_CONTROLLER_CLK(clk),
      .Reset(Reset),
      .INIT_DONE(INIT_DONE),
      .Start(Start),
      .START_ADDR(START_ADDR),
      .WORD_COUNT(WORD_COUNT),
      .Busy(Busy),
      .Done(Done),
      .DATA_ADDR(DATA_ADDR),
      .RW_READ(RW_READ),
      .RW_WRITE(RW_WRITE),
      .RW_ACK(RW_ACK),
      .DATA_READ(DATA_READ),
      .OUT_DATA(OUT_DATA),
      .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY)
`ifdef SDRAM_READ_STREAMER_ABORT_EN
      ,
      .Abort(abort)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Data the controller model returns for an address; 0x400..0x403 give 0xA0..0xA3.
   function automatic logic [31:0] word_of(input logic [24:0] a);
      return 32'(a) + 32'h0000_00A0 - 32'h0000_0400;
   endfunction

   task automatic expect_run(input logic [24:0] base, input int n);
      logic [24:0] a;
      a = base;
      for (int i = 0; i < n; i++) begin
         exp_addr_q.push_back(a);
         exp_data_q.push_back(word_of(a));
         a = a + 25'd1;
      end
   endtask

   // One clock: score the pop the coming edge performs, then run the controller model after it.
   task automatic step();
      if (!Reset && OUT_VALID && OUT_READY) begin
         check("pop_expected", 32'(exp_data_q.size() != 0), 32'd1);
         if (exp_data_q.size() != 0) check("out_data", OUT_DATA, exp_data_q.pop_front());
      end
      @(posedge clk);
      #1;
      if (Done) done_cnt++;
      if (RW_ACK) begin
         RW_ACK = 1'b0;
         ack_wait = 0;
         check("read_low_after_ack", 32'(RW_READ), 32'd0);
      end else if (RW_READ && !Reset) begin
         if (ack_wait >= ack_lat) begin
            check("read_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) check("read_addr", 32'(DATA_ADDR), 32'(exp_addr_q.pop_front()));
            RW_ACK    = 1'b1;
            DATA_READ = word_of(DATA_ADDR);
            reads++;
            ack_wait  = 0;
         end else begin
            ack_wait++;
         end
      end else begin
         ack_wait = 0;
      end
   endtask

   task automatic wait_done(input int limit);
      int start_cnt;
      start_cnt = done_cnt;
      for (int i = 0; i < limit && done_cnt == start_cnt; i++) step();
   endtask

   task automatic drain(input int limit);
      for (int i = 0; i < limit && exp_data_q.size() != 0; i++) step();
      step();
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b1; INIT_DONE = 1'b0; Start = 1'b0; START_ADDR = '0; WORD_COUNT = '0;
      RW_ACK = 1'b0; DATA_READ = '0; OUT_READY = 1'b0;
      repeat (3) step();
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_read", 32'(RW_READ), 32'd0);
      check("rst_write", 32'(RW_WRITE), 32'd0);
      check("rst_addr", 32'(DATA_ADDR), 32'd0);
      check("rst_valid", 32'(OUT_VALID), 32'd0);
      Reset = 1'b0;
      step();

      // Start before INIT_DONE is ignored
      START_ADDR = 25'h0000400; WORD_COUNT = 16'd4; Start = 1'b1;
      step();
      Start = 1'b0;
      check("preinit_read", 32'(RW_READ), 32'd0);
      check("preinit_busy", 32'(Busy), 32'd0);
      repeat (3) step();
      check("preinit_reads", 32'(reads), 32'd0);
      INIT_DONE = 1'b1;
      step();
      INIT_DONE = 1'b0;
      step();

      // Four words from 0x400, consumer always ready
      OUT_READY = 1'b1; ack_lat = 1; reads = 0; done0 = done_cnt;
      expect_run(25'h0000400, 4);
      Start = 1'b1;
      step();
      Start = 1'b0;
      check("start_latency_read", 32'(RW_READ), 32'd1);
      check("first_addr", 32'(DATA_ADDR), 32'h0000_0400);
      check("run1_busy", 32'(Busy), 32'd1);
      wait_done(200);
      check("run1_busy_after", 32'(Busy), 32'd0);
      drain(50);
      check("run1_reads", 32'(reads), 32'd4);
      check("run1_done_once", 32'(done_cnt - done0), 32'd1);
      check("run1_drained", 32'(exp_data_q.size()), 32'd0);

      // Twenty words with the consumer stalled: only DEPTH reads may be issued
      OUT_READY = 1'b0; reads = 0; done0 = done_cnt;
      START_ADDR = 25'h0002000; WORD_COUNT = 16'd20;
      expect_run(25'h0002000, 20);
      Start = 1'b1;
      step();
      Start = 1'b0;
      repeat (100) step();
      check("stall_reads", 32'(reads), 32'd16);
      check("stall_read_low", 32'(RW_READ), 32'd0);
      check("stall_valid", 32'(OUT_VALID), 32'd1);
      check("stall_busy", 32'(Busy), 32'd1);
      check("stall_no_done", 32'(done_cnt - done0), 32'd0);
      START_ADDR = 25'h0007777; WORD_COUNT = 16'd1; Start = 1'b1;
      step();
      Start = 1'b0;
      OUT_READY = 1'b1;
      wait_done(300);
      drain(50);
      repeat (4) step();
      check("stall_reads_total", 32'(reads), 32'd20);
      check("stall_done_once", 32'(done_cnt - done0), 32'd1);
      check("stall_drained", 32'(exp_data_q.size()), 32'd0);

      // Address wrap at the top of the 25-bit space, immediate acks
      ack_lat = 0; reads = 0; done0 = done_cnt;
      exp_addr_q.push_back(25'h1FFFFFE); exp_data_q.push_back(word_of(25'h1FFFFFE));
      exp_addr_q.push_back(25'h1FFFFFF); exp_data_q.push_back(word_of(25'h1FFFFFF));
      exp_addr_q.push_back(25'h0000000); exp_data_q.push_back(word_of(25'h0000000));
      START_ADDR = 25'h1FFFFFE; WORD_COUNT = 16'd3; Start = 1'b1;
      step();
      Start = 1'b0;
      wait_done(100);
      drain(20);
      check("wrap_reads", 32'(reads), 32'd3);
      check("wrap_done_once", 32'(done_cnt - done0), 32'd1);
      check("wrap_addr_used", 32'(exp_addr_q.size()), 32'd0);

      // Zero-length run: Done two cycles after Start, no request
      reads = 0;
      START_ADDR = 25'h0000055; WORD_COUNT = 16'd0; Start = 1'b1;
      step();
      Start = 1'b0;
      check("zero_done_n1", 32'(Done), 32'd0);
      step();
      check("zero_done_n2", 32'(Done), 32'd1);
      step();
      check("zero_done_n3", 32'(Done), 32'd0);
      check("zero_reads", 32'(reads), 32'd0);
      check("zero_busy", 32'(Busy), 32'd0);

      // Spurious ack while idle must not push
      RW_ACK = 1'b1; DATA_READ = 32'hDEAD_BEEF;
      step();
      step();
      check("spurious_ack_valid", 32'(OUT_VALID), 32'd0);

      // Reset while waiting for the 4th ack with 3 words buffered
      OUT_READY = 1'b0; ack_lat = 3; reads = 0;
      expect_run(25'h0000300, 6);
      START_ADDR = 25'h0000300; WORD_COUNT = 16'd6; Start = 1'b1;
      step();
      Start = 1'b0;
      for (int i = 0; i < 200 && !(reads == 3 && RW_READ && !RW_ACK); i++) step();
      check("pre_reset_reads", 32'(reads), 32'd3);
      check("pre_reset_valid", 32'(OUT_VALID), 32'd1);
      done0 = done_cnt;
      Reset = 1'b1;
      step();
      check("mid_reset_read", 32'(RW_READ), 32'd0);
      check("mid_reset_valid", 32'(OUT_VALID), 32'd0);
      check("mid_reset_busy", 32'(Busy), 32'd0);
      check("mid_reset_done", 32'(Done), 32'd0);
      Reset = 1'b0;
      exp_addr_q.delete();
      exp_data_q.delete();
      repeat (3) step();
      check("mid_reset_no_done", 32'(done_cnt - done0), 32'd0);

      // Reset also forgets INIT_DONE
      START_ADDR = 25'h0000000; WORD_COUNT = 16'd2; Start = 1'b1;
      step();
      Start = 1'b0;
      check("init_cleared_read", 32'(RW_READ), 32'd0);
      check("init_cleared_busy", 32'(Busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
